// File: rtl/learn_sequencer_pkg.sv
// Shared field widths, rest code and state encoding for the guided-learning sequencer.
package learn_sequencer_pkg;

    localparam int LS_OCT_BITS  = 3;
    localparam int LS_NOTE_BITS = 4;
    localparam int LS_LEN_BITS  = 3;
    localparam int LS_SONG_BITS = 3;
    localparam int REST_NOTE    = 0;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_WAIT_KEY = 3'd2;
    localparam logic [2:0] S_PLAY     = 3'd3;
    localparam logic [2:0] S_NEXT     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = S_IDLE,
        ST_FETCH    = S_FETCH,
        ST_WAIT_KEY = S_WAIT_KEY,
        ST_PLAY     = S_PLAY,
        ST_NEXT     = S_NEXT,
        ST_DONE     = S_DONE
    } state_t;

endpackage

// File: rtl/learn_sequencer_timeout.sv
// Loadable down-counter: clear reloads the full period, run counts down,
// expire flags the terminal count while running.
module learn_timeout #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expire
);
    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (i_clear)
            r_count <= LOAD;
        else if (i_run && (r_count != '0))
            r_count <= r_count - 1'b1;
    end

    assign o_expire = i_run && (r_count == '0);

endmodule

// File: rtl/learn_sequencer.sv
// Guided-learning sequencer: lights the target key, waits for the matching
// press (or a timeout), plays the note, then steps to the next song entry.
//   state    | meaning
//   IDLE     | inactive, waiting for start
//   FETCH    | capture ROM entry for the current step
//   WAIT_KEY | target LED lit, waiting for player key or timeout
//   PLAY     | sound engine running, waiting for snd_done
//   NEXT     | advance step or finish
//   DONE     | song complete, start restarts
module learn_sequencer
    import learn_sequencer_pkg::*;
#(
    parameter int NOTE_KEYS      = 7,
    parameter int OCT_BITS       = LS_OCT_BITS,
    parameter int NOTE_BITS      = LS_NOTE_BITS,
    parameter int LEN_BITS       = LS_LEN_BITS,
    parameter int SONG_BITS      = LS_SONG_BITS,
    parameter int STEP_BITS      = 6,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int AUTO_DEMO      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic [SONG_BITS-1:0] song_sel,
    output logic [SONG_BITS-1:0] rom_song,
    output logic [STEP_BITS-1:0] rom_step,
    input  logic [OCT_BITS-1:0]  rom_octave,
    input  logic [NOTE_BITS-1:0] rom_note,
    input  logic [LEN_BITS-1:0]  rom_length,
    input  logic [STEP_BITS-1:0] rom_track,
    input  logic                 key_valid,
    input  logic [OCT_BITS-1:0]  key_octave,
    input  logic [NOTE_BITS-1:0] key_note,
    output logic                 snd_start,
    output logic [OCT_BITS-1:0]  snd_octave,
    output logic [NOTE_BITS-1:0] snd_note,
    output logic [LEN_BITS-1:0]  snd_length,
    input  logic                 snd_done,
    output logic [NOTE_KEYS-1:0] note_led,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [STEP_BITS:0]   hits,
    output logic [STEP_BITS:0]   misses
);
    state_t               r_state, w_state_nxt;
    logic [SONG_BITS-1:0] r_song, w_song_nxt;
    logic [STEP_BITS-1:0] r_step, w_step_nxt;
    logic [OCT_BITS-1:0]  r_goal_octave, w_goal_octave_nxt;
    logic [NOTE_BITS-1:0] r_goal_note, w_goal_note_nxt;
    logic [STEP_BITS-1:0] r_goal_track, w_goal_track_nxt;
    logic [OCT_BITS-1:0]  r_snd_octave, w_snd_octave_nxt;
    logic [NOTE_BITS-1:0] r_snd_note, w_snd_note_nxt;
    logic [LEN_BITS-1:0]  r_snd_length, w_snd_length_nxt;
    logic                 r_snd_start, w_snd_start_nxt;
    logic                 r_err, w_err_nxt;
    logic [STEP_BITS:0]   r_hits, w_hits_nxt;
    logic [STEP_BITS:0]   r_misses, w_misses_nxt;
    logic                 w_tmr_clear, w_tmr_run, w_tmr_expire, w_key_match;
    logic [NOTE_KEYS-1:0] w_led;

    learn_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_tmr_clear),
        .i_run    (w_tmr_run),
        .o_expire (w_tmr_expire)
    );

    assign w_key_match = (key_note == r_goal_note) && (key_octave == r_goal_octave);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_song        <= '0;
            r_step        <= '0;
            r_goal_octave <= '0;
            r_goal_note   <= '0;
            r_goal_track  <= '0;
            r_snd_octave  <= '0;
            r_snd_note    <= '0;
            r_snd_length  <= '0;
            r_snd_start   <= 1'b0;
            r_err         <= 1'b0;
            r_hits        <= '0;
            r_misses      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_song        <= w_song_nxt;
            r_step        <= w_step_nxt;
            r_goal_octave <= w_goal_octave_nxt;
            r_goal_note   <= w_goal_note_nxt;
            r_goal_track  <= w_goal_track_nxt;
            r_snd_octave  <= w_snd_octave_nxt;
            r_snd_note    <= w_snd_note_nxt;
            r_snd_length  <= w_snd_length_nxt;
            r_snd_start   <= w_snd_start_nxt;
            r_err         <= w_err_nxt;
            r_hits        <= w_hits_nxt;
            r_misses      <= w_misses_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_song_nxt        = r_song;
        w_step_nxt        = r_step;
        w_goal_octave_nxt = r_goal_octave;
        w_goal_note_nxt   = r_goal_note;
        w_goal_track_nxt  = r_goal_track;
        w_snd_octave_nxt  = r_snd_octave;
        w_snd_note_nxt    = r_snd_note;
        w_snd_length_nxt  = r_snd_length;
        w_snd_start_nxt   = 1'b0;
        w_err_nxt         = 1'b0;
        w_hits_nxt        = r_hits;
        w_misses_nxt      = r_misses;
        w_tmr_clear       = 1'b0;
        w_tmr_run         = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_song_nxt   = song_sel;
                        w_step_nxt   = '0;
                        w_hits_nxt   = '0;
                        w_misses_nxt = '0;
                        w_state_nxt  = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    w_goal_octave_nxt = rom_octave;
                    w_goal_note_nxt   = rom_note;
                    w_goal_track_nxt  = rom_track;
                    w_snd_octave_nxt  = rom_octave;
                    w_snd_note_nxt    = rom_note;
                    w_snd_length_nxt  = rom_length;
                    if (rom_note == NOTE_BITS'(REST_NOTE)) begin
                        w_snd_start_nxt = 1'b1;
                        w_state_nxt     = ST_PLAY;
                    end else begin
                        w_tmr_clear = 1'b1;
                        w_state_nxt = ST_WAIT_KEY;
                    end
                end
                ST_WAIT_KEY: begin
                    w_tmr_run = 1'b1;
                    // A press in the expiry cycle takes priority over the auto-demo.
                    if (key_valid) begin
                        if (w_key_match) begin
                            w_hits_nxt      = (&r_hits) ? r_hits : r_hits + 1'b1;
                            w_snd_start_nxt = 1'b1;
                            w_state_nxt     = ST_PLAY;
                        end else begin
                            w_misses_nxt = (&r_misses) ? r_misses : r_misses + 1'b1;
                            w_err_nxt    = 1'b1;
                            w_tmr_clear  = 1'b1;
                        end
                    end else if ((AUTO_DEMO != 0) && w_tmr_expire) begin
                        w_misses_nxt    = (&r_misses) ? r_misses : r_misses + 1'b1;
                        w_snd_start_nxt = 1'b1;
                        w_state_nxt     = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (snd_done)
                        w_state_nxt = ST_NEXT;
                end
                ST_NEXT: begin
                    if ((r_step == r_goal_track) || (&r_step)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_step_nxt  = r_step + 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_led = '0;
        if ((r_state == ST_WAIT_KEY) || (r_state == ST_PLAY)) begin
            for (int i = 0; i < NOTE_KEYS; i++)
                if (r_goal_note == NOTE_BITS'(i + 1))
                    w_led[i] = 1'b1;
        end
    end

    assign rom_song   = r_song;
    assign rom_step   = r_step;
    assign snd_start  = r_snd_start;
    assign snd_octave = r_snd_octave;
    assign snd_note   = r_snd_note;
    assign snd_length = r_snd_length;
    assign note_led   = w_led;
    assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done       = (r_state == ST_DONE);
    assign err        = r_err;
    assign hits       = r_hits;
    assign misses     = r_misses;

endmodule

// File: tb/tb_learn_sequencer.sv
// Self-checking bench for learn_sequencer: single-step vector table, scripted
// corner sequences, and random songs scored by a plan-level reference model.
module tb_learn_sequencer;
    localparam int T = 16;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, start = 1'b0;
    logic [2:0] song_sel = '0;
    logic [2:0] rom_song;
    logic [5:0] rom_step;
    logic [2:0] rom_octave;
    logic [3:0] rom_note;
    logic [2:0] rom_length;
    logic [5:0] rom_track;
    logic       key_valid = 1'b0;
    logic [2:0] key_octave = '0;
    logic [3:0] key_note = '0;
    logic       snd_start;
    logic [2:0] snd_octave;
    logic [3:0] snd_note;
    logic [2:0] snd_length;
    logic       snd_done = 1'b0;
    logic [6:0] note_led;
    logic       busy, done, err;
    logic [6:0] hits, misses;

    int checks = 0, errors = 0, start_cnt = 0, err_cnt = 0;

    logic [2:0] m_oct [8][64];
    logic [3:0] m_note[8][64];
    logic [2:0] m_len [8][64];
    logic [5:0] m_track[8];
    int         p_wrong[64];
    int         p_mode[64];   // 0 correct press, 1 timeout, 2 correct press in expiry cycle

    typedef struct packed {
        logic [2:0] g_oct;
        logic [3:0] g_note;
        logic [2:0] k_oct;
        logic [3:0] k_note;
        logic [6:0] exp_led;
        logic       exp_hit;
    } vec_t;
    vec_t vecs[7];

    assign rom_octave = m_oct[rom_song][rom_step];
    assign rom_note   = m_note[rom_song][rom_step];
    assign rom_length = m_len[rom_song][rom_step];
    assign rom_track  = m_track[rom_song];

    learn_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .song_sel(song_sel),
        .rom_song(rom_song), .rom_step(rom_step), .rom_octave(rom_octave),
        .rom_note(rom_note), .rom_length(rom_length), .rom_track(rom_track),
        .key_valid(key_valid), .key_octave(key_octave), .key_note(key_note),
        .snd_start(snd_start), .snd_octave(snd_octave), .snd_note(snd_note),
        .snd_length(snd_length), .snd_done(snd_done), .note_led(note_led),
        .busy(busy), .done(done), .err(err), .hits(hits), .misses(misses)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (snd_start) start_cnt++;
        if (err) err_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [2:0] o, input logic [3:0] n);
        key_valid = 1'b1; key_octave = o; key_note = n;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic run_song(input int s, input int n);
        int exp_hits, exp_miss, exp_err, s0, e0, cnt, lat;
        logic [3:0] nt;
        logic [2:0] oc;
        exp_hits = 0; exp_miss = 0; exp_err = 0;
        for (int k = 0; k < n; k++) begin
            if (m_note[s][k] != 4'd0) begin
                exp_err  += p_wrong[k];
                exp_miss += p_wrong[k] + ((p_mode[k] == 1) ? 1 : 0);
                exp_hits += (p_mode[k] == 1) ? 0 : 1;
            end
        end
        m_track[s] = 6'(n - 1);
        s0 = start_cnt; e0 = err_cnt;
        song_sel = 3'(s); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            nt = m_note[s][k]; oc = m_oct[s][k];
            lat = (k == 0) ? 2 : 3;
            cnt = 1;
            if (nt == 4'd0) begin
                while (!snd_start && cnt < 40) begin @(negedge clk); cnt++; end
                chk("rest_latency", cnt, lat);
                chk("rest_led", note_led, 0);
            end else begin
                while (note_led == '0 && cnt < 40) begin @(negedge clk); cnt++; end
                chk("led_latency", cnt, lat);
                chk("led_onehot", note_led, 7'd1 << (nt - 4'd1));
                for (int w = 0; w < p_wrong[k]; w++) begin
                    if (w % 2 == 0) press(oc, (nt == 4'd1) ? 4'd2 : nt - 4'd1);
                    else            press(oc + 3'd1, nt);
                    chk("wrong_err", err, 1);
                    chk("wrong_no_snd", snd_start, 0);
                end
                if (p_mode[k] == 1) begin
                    cnt = 0;
                    while (!snd_start && cnt < 40) begin @(negedge clk); cnt++; end
                    chk("timeout_latency", cnt, T);
                end else begin
                    if (p_mode[k] == 2) repeat (T - 1) @(negedge clk);
                    press(oc, nt);
                    chk("hit_snd_start", snd_start, 1);
                end
            end
            chk("step_index", rom_step, k);
            chk("snd_note", snd_note, nt);
            chk("snd_octave", snd_octave, oc);
            chk("snd_length", snd_length, m_len[s][k]);
            repeat ($urandom_range(1, 4)) @(negedge clk);
            snd_done = 1'b1;
            @(negedge clk);
            snd_done = 1'b0;
        end
        @(negedge clk);
        chk("song_done", done, 1);
        chk("song_busy", busy, 0);
        chk("done_led", note_led, 0);
        chk("song_hits", hits, exp_hits);
        chk("song_misses", misses, exp_miss);
        chk("snd_start_pulses", start_cnt - s0, n);
        chk("err_pulses", err_cnt - e0, exp_err);
    endtask

    initial begin
        for (int s = 0; s < 8; s++) begin
            m_track[s] = '0;
            for (int k = 0; k < 64; k++) begin
                m_oct[s][k] = '0; m_note[s][k] = '0; m_len[s][k] = '0;
            end
        end
        vecs[0] = '{3'd4, 4'd1, 3'd4, 4'd1, 7'b0000001, 1'b1};
        vecs[1] = '{3'd4, 4'd7, 3'd4, 4'd7, 7'b1000000, 1'b1};
        vecs[2] = '{3'd2, 4'd3, 3'd2, 4'd2, 7'b0000100, 1'b0};
        vecs[3] = '{3'd2, 4'd3, 3'd5, 4'd3, 7'b0000100, 1'b0};
        vecs[4] = '{3'd0, 4'd5, 3'd0, 4'd5, 7'b0010000, 1'b1};
        vecs[5] = '{3'd3, 4'd9, 3'd3, 4'd9, 7'b0000000, 1'b1};
        vecs[6] = '{3'd7, 4'd4, 3'd6, 4'd4, 7'b0001000, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {rom_song, rom_step, snd_start, snd_octave, snd_note, snd_length,
                              note_led, busy, done, err}, 0);
        chk("reset_hits", hits, 0);
        chk("reset_misses", misses, 0);
        rst = 1'b0; en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            m_oct[7][0] = vecs[i].g_oct; m_note[7][0] = vecs[i].g_note;
            m_len[7][0] = 3'd1; m_track[7] = '0;
            song_sel = 3'd7; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            chk("vec_led", note_led, vecs[i].exp_led);
            press(vecs[i].k_oct, vecs[i].k_note);
            chk("vec_snd_start", snd_start, vecs[i].exp_hit);
            chk("vec_err", err, !vecs[i].exp_hit);
            chk("vec_hits", hits, vecs[i].exp_hit);
            chk("vec_misses", misses, !vecs[i].exp_hit);
            en = 1'b0;
            @(negedge clk);
            en = 1'b1;
            chk("vec_idle", busy, 0);
        end

        // three correct presses
        for (int k = 0; k < 3; k++) begin
            m_oct[0][k] = 3'd4; m_note[0][k] = 4'(2 * k + 1); m_len[0][k] = 3'd2;
            p_wrong[k] = 0; p_mode[k] = 0;
        end
        run_song(0, 3);
        // wrong key then right key
        m_oct[1][0] = 3'd4; m_note[1][0] = 4'd3; m_len[1][0] = 3'd3;
        p_wrong[0] = 1; p_mode[0] = 0;
        run_song(1, 1);
        // timeout then normal step
        m_oct[2][0] = 3'd1; m_note[2][0] = 4'd6; m_len[2][0] = 3'd5;
        m_oct[2][1] = 3'd2; m_note[2][1] = 4'd2; m_len[2][1] = 3'd1;
        p_wrong[0] = 0; p_mode[0] = 1; p_wrong[1] = 0; p_mode[1] = 0;
        run_song(2, 2);
        // press in the expiry cycle
        m_oct[3][0] = 3'd5; m_note[3][0] = 4'd4; m_len[3][0] = 3'd7;
        p_wrong[0] = 0; p_mode[0] = 2;
        run_song(3, 1);
        // rest in the middle
        m_oct[4][0] = 3'd3; m_note[4][0] = 4'd2; m_len[4][0] = 3'd2;
        m_oct[4][1] = 3'd3; m_note[4][1] = 4'd0; m_len[4][1] = 3'd4;
        m_oct[4][2] = 3'd3; m_note[4][2] = 4'd6; m_len[4][2] = 3'd2;
        for (int k = 0; k < 3; k++) begin p_wrong[k] = 0; p_mode[k] = 0; end
        run_song(4, 3);

        // en drop during PLAY, start ignored while busy
        m_oct[5][0] = 3'd3; m_note[5][0] = 4'd2; m_len[5][0] = 3'd1;
        m_oct[5][1] = 3'd3; m_note[5][1] = 4'd4; m_len[5][1] = 3'd1;
        m_track[5] = 6'd1;
        song_sel = 3'd5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("hand_led", note_led, 7'b0000010);
        song_sel = 3'd6; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_start_song", rom_song, 5);
        chk("busy_start_step", rom_step, 0);
        press(3'd3, 4'd2);
        chk("hand_snd_start", snd_start, 1);
        en = 1'b0;
        @(negedge clk);
        chk("en_drop_busy", busy, 0);
        chk("en_drop_snd", snd_start, 0);
        chk("en_drop_led", note_led, 0);
        chk("en_drop_hits", hits, 1);
        en = 1'b1;
        // en drop together with a correct key: no sound request may leak
        song_sel = 3'd5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        key_valid = 1'b1; key_octave = 3'd3; key_note = 4'd2; en = 1'b0;
        @(negedge clk);
        key_valid = 1'b0;
        chk("en_key_snd", snd_start, 0);
        chk("en_key_busy", busy, 0);
        en = 1'b1;
        @(negedge clk);
        chk("en_key_snd_late", snd_start, 0);
        // rst mid-WAIT_KEY
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        press(3'd3, 4'd5);
        chk("pre_rst_misses", misses, 1);
        key_valid = 1'b1; key_octave = 3'd3; key_note = 4'd2; rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_led", note_led, 0);
        chk("rst_misses", misses, 0);
        @(negedge clk);
        chk("rst_snd", snd_start, 0);
        chk("rst_err", err, 0);
        key_valid = 1'b0; rst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                m_note[6][k] = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 7));
                m_oct[6][k]  = 3'($urandom_range(0, 7));
                m_len[6][k]  = 3'($urandom_range(0, 7));
                p_wrong[k]   = $urandom_range(0, 2);
                p_mode[k]    = $urandom_range(0, 2);
            end
            run_song(6, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
